// File: rtl/sdram_pattern_tester.sv
// sdram_pattern_tester: Avalon-MM master that fills a word range of SDRAM with a
// 16-bit Galois LFSR pattern, reads it back with up to MAX_PENDING pipelined reads,
// and counts mismatches. Status is shown on busy/done/pass/err_count and on ledr.
// Optional feature macro SDRAM_TESTER_ERR_CAPTURE_EN adds first_err_addr and
// first_err_data, backed by a FIFO of issued read addresses.
module sdram_pattern_tester #(
  parameter int          ADDR_W      = 25,
  parameter int          BASE_WORD   = 0,
  parameter int          NUM_WORDS   = 1024,
  parameter logic [15:0] SEED        = 16'hACE1,
  parameter int          MAX_PENDING = 8,
  parameter int          BLINK_DIV   = 25000000
) (
  input  logic              ref_clk,
  input  logic              fpga_reset_n,
  input  logic              start,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_write,
  output logic [15:0]       avm_writedata,
  output logic [1:0]        avm_byteenable,
  output logic              avm_read,
  input  logic [15:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [15:0]       err_count,
  output logic              ledr
`ifdef SDRAM_TESTER_ERR_CAPTURE_EN
  ,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [15:0]       first_err_data
`endif
);

  localparam int                PEND_W    = $clog2(MAX_PENDING) + 1;
  localparam logic [PEND_W-1:0] PEND_MAX  = PEND_W'(MAX_PENDING);
  localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
  localparam logic [PEND_W-1:0] PEND_ZERO = PEND_W'(0);
  localparam logic [25:0]       LAST_WORD = 26'(NUM_WORDS - 1);
  localparam logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(BASE_WORD);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam int                FAST_DIV  = ((BLINK_DIV / 4) > 0) ? (BLINK_DIV / 4) : 1;
  localparam logic [31:0]       SLOW_LIM  = 32'(BLINK_DIV - 1);
  localparam logic [31:0]       FAST_LIM  = 32'(FAST_DIV - 1);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  // One Galois step, polynomial x^16+x^14+x^13+x^11+1 (feedback mask 16'hB400).
  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    lfsr_step = {1'b0, v[15:1]} ^ ({16{v[0]}} & 16'hB400);
  endfunction

  state_t              state_r, state_s;
  logic [ADDR_W-1:0]   addr_r;
  logic [15:0]         wr_lfsr_r, exp_lfsr_r, err_r, err_s;
  logic [25:0]         word_cnt_r;
  logic [PEND_W-1:0]   pend_r, pend_s;
  logic                write_r, read_r, busy_r, done_r, pass_r, led_r;
  logic [31:0]         blink_r;
  logic                start_go_s, wr_acc_s, rd_acc_s, rdv_s, last_s, mismatch_s;

  // Handshake strobes, pending-count update and saturating error count.
  always_comb begin
    start_go_s = start && ((state_r == S_IDLE) || (state_r == S_DONE));
    wr_acc_s   = write_r && !avm_waitrequest;
    rd_acc_s   = read_r && !avm_waitrequest;
    rdv_s      = avm_readdatavalid && ((state_r == S_READ) || (state_r == S_DRAIN));
    last_s     = (word_cnt_r == LAST_WORD);
    mismatch_s = rdv_s && (avm_readdata != exp_lfsr_r);
    pend_s     = pend_r;
    err_s      = err_r;
    if (rd_acc_s && !rdv_s) begin
      pend_s = pend_r + PEND_ONE;
    end else if (!rd_acc_s && rdv_s && (pend_r != PEND_ZERO)) begin
      pend_s = pend_r - PEND_ONE;
    end else begin
      pend_s = pend_r;
    end
    if (mismatch_s && (err_r != 16'hFFFF)) begin
      err_s = err_r + 16'h0001;
    end else begin
      err_s = err_r;
    end
  end

  // Next-state logic of the run sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE, S_DONE: if (start) state_s = S_WRITE; else state_s = state_r;
      S_WRITE:        if (wr_acc_s && last_s) state_s = S_READ; else state_s = S_WRITE;
      S_READ:         if (rd_acc_s && last_s) state_s = S_DRAIN; else state_s = S_READ;
      S_DRAIN:        if (pend_r == PEND_ZERO) state_s = S_DONE; else state_s = S_DRAIN;
      default:        state_s = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) state_r <= S_IDLE;
    else               state_r <= state_s;
  end

  // Request generation, address/data sequencing, comparison and status.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      addr_r     <= {ADDR_W{1'b0}};
      wr_lfsr_r  <= 16'h0000;
      exp_lfsr_r <= 16'h0000;
      word_cnt_r <= 26'd0;
      pend_r     <= PEND_ZERO;
      err_r      <= 16'h0000;
      write_r    <= 1'b0;
      read_r     <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else if (start_go_s) begin
      addr_r     <= BASE_ADDR;
      wr_lfsr_r  <= SEED;
      exp_lfsr_r <= SEED;
      word_cnt_r <= 26'd0;
      pend_r     <= PEND_ZERO;
      err_r      <= 16'h0000;
      write_r    <= 1'b1;
      read_r     <= 1'b0;
      busy_r     <= 1'b1;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
    end else begin
      pend_r <= pend_s;
      err_r  <= err_s;
      if (rdv_s) exp_lfsr_r <= lfsr_step(exp_lfsr_r);
      case (state_r)
        S_WRITE: begin
          if (wr_acc_s) begin
            wr_lfsr_r <= lfsr_step(wr_lfsr_r);
            if (last_s) begin
              // Go straight to reading: the first read is requested next cycle.
              addr_r     <= BASE_ADDR;
              word_cnt_r <= 26'd0;
              write_r    <= 1'b0;
              read_r     <= 1'b1;
            end else begin
              addr_r     <= addr_r + ADDR_ONE;
              word_cnt_r <= word_cnt_r + 26'd1;
            end
          end
        end
        S_READ: begin
          // Throttle on the count we will have next cycle so pending never exceeds the limit.
          read_r <= (state_s == S_READ) && (pend_s < PEND_MAX);
          if (rd_acc_s && !last_s) begin
            addr_r     <= addr_r + ADDR_ONE;
            word_cnt_r <= word_cnt_r + 26'd1;
          end
        end
        S_DRAIN: begin
          if (pend_r == PEND_ZERO) begin
            busy_r <= 1'b0;
            done_r <= 1'b1;
            pass_r <= (err_r == 16'h0000);
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Status LED: slow blink while busy, solid on pass, fast blink on failure.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      led_r   <= 1'b0;
      blink_r <= 32'd0;
    end else if (start_go_s) begin
      led_r   <= 1'b0;
      blink_r <= 32'd0;
    end else if (busy_r) begin
      if (blink_r >= SLOW_LIM) begin
        blink_r <= 32'd0;
        led_r   <= ~led_r;
      end else begin
        blink_r <= blink_r + 32'd1;
      end
    end else if (done_r && pass_r) begin
      led_r   <= 1'b1;
      blink_r <= 32'd0;
    end else if (done_r) begin
      if (blink_r >= FAST_LIM) begin
        blink_r <= 32'd0;
        led_r   <= ~led_r;
      end else begin
        blink_r <= blink_r + 32'd1;
      end
    end else begin
      led_r   <= 1'b0;
      blink_r <= 32'd0;
    end
  end

`ifdef SDRAM_TESTER_ERR_CAPTURE_EN
  localparam int               PTR_W   = $clog2(MAX_PENDING);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [ADDR_W-1:0] fifo_mem_r [MAX_PENDING];
  logic [PTR_W-1:0]  fifo_wp_r, fifo_rp_r;
  logic [ADDR_W-1:0] ferr_addr_r;
  logic [15:0]       ferr_data_r;

  // Address of each accepted read, consumed in order as its data returns.
  always_ff @(posedge ref_clk) begin
    if (rd_acc_s) fifo_mem_r[fifo_wp_r] <= avm_address;
  end

  // FIFO pointers and capture of the first mismatch of a run.
  always_ff @(posedge ref_clk or negedge fpga_reset_n) begin
    if (!fpga_reset_n) begin
      fifo_wp_r   <= {PTR_W{1'b0}};
      fifo_rp_r   <= {PTR_W{1'b0}};
      ferr_addr_r <= {ADDR_W{1'b0}};
      ferr_data_r <= 16'h0000;
    end else if (start_go_s) begin
      fifo_wp_r   <= {PTR_W{1'b0}};
      fifo_rp_r   <= {PTR_W{1'b0}};
      ferr_addr_r <= {ADDR_W{1'b0}};
      ferr_data_r <= 16'h0000;
    end else begin
      if (rd_acc_s) fifo_wp_r <= fifo_wp_r + PTR_ONE;
      if (rdv_s && (pend_r != PEND_ZERO)) fifo_rp_r <= fifo_rp_r + PTR_ONE;
      if (mismatch_s && (err_r == 16'h0000)) begin
        ferr_addr_r <= fifo_mem_r[fifo_rp_r];
        ferr_data_r <= avm_readdata;
      end
    end
  end

  assign first_err_addr = ferr_addr_r;
  assign first_err_data = ferr_data_r;
`endif

  assign avm_address    = addr_r;
  assign avm_write      = write_r;
  assign avm_writedata  = wr_lfsr_r;
  assign avm_byteenable = 2'b11;
  assign avm_read       = read_r;
  assign busy           = busy_r;
  assign done           = done_r;
  assign pass           = pass_r;
  assign err_count      = err_r;
  assign ledr           = led_r;

endmodule

// File: doc/sdram_pattern_tester.md
Name: sdram_pattern_tester

Overview:
- Avalon-MM master sitting directly upstream of the SoC's SDRAM controller slave port (16-bit x 32M-word part).
- On start, writes a pseudo-random LFSR pattern over a word range, reads it back with pipelined reads, and compares.
- Reports busy/done/pass and an error count, and drives the board LED status output.

Parameters:
- ADDR_W, 25, Avalon word-address width.
- BASE_WORD, 0, first word address tested.
- NUM_WORDS, 1024, words tested (>=1, BASE_WORD+NUM_WORDS <= 2^ADDR_W).
- SEED, 16'hACE1, LFSR seed; must be nonzero.
- MAX_PENDING, 8, maximum outstanding reads (power of two, 2..32).
- BLINK_DIV, 25000000, ref_clk cycles per LED half-period while busy.

Ports:
- ref_clk  in  1  sole clock.
- fpga_reset_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- avm_address  out  ADDR_W  word address.
- avm_write  out  1  write request.
- avm_writedata  out  16  write data.
- avm_byteenable  out  2  always 2'b11.
- avm_read  out  1  read request.
- avm_readdata  in  16  read data.
- avm_readdatavalid  in  1  read data strobe.
- avm_waitrequest  in  1  slave stall.
- busy  out  1  run in progress.
- done  out  1  run finished; held until next start.
- pass  out  1  valid when done; 1 = zero mismatches.
- err_count  out  16  mismatch count, saturates at 16'hFFFF.
- ledr  out  1  status LED.

Behaviour:
- Reset is asynchronous and active-low. Clock: ref_clk; reset: fpga_reset_n. All state is asserted asynchronously, released synchronously to ref_clk.
- Reset values: avm_read=0, avm_write=0, avm_address=0, avm_writedata=0, busy=0, done=0, pass=0, err_count=0, ledr=0.
- LFSR: 16-bit Galois, taps x^16+x^14+x^13+x^11+1, advances one step per accepted word.
- Separate generators are used for write data and expected data; both load SEED at run start.
- FSM states: IDLE, WRITE, READ, DRAIN, DONE.
  - IDLE/DONE + start: clear err_count/done/pass, load LFSRs, set address=BASE_WORD, busy=1, go to WRITE. start in WRITE/READ/DRAIN is ignored.
  - WRITE: avm_write=1 with address/data held stable while avm_waitrequest=1. On a cycle with write && !waitrequest: advance address and LFSR. After the NUM_WORDS-th accept: deassert write, reset address to BASE_WORD, go to READ with no idle cycle required.
  - READ: avm_read=1 whenever pending<MAX_PENDING; address held while waitrequest=1.
    - pending +1 per accepted read and -1 per readdatavalid; simultaneous accept and valid leaves it unchanged.
    - After NUM_WORDS reads are accepted, go to DRAIN.
  - DRAIN: no requests; wait until pending==0, then go to DONE.
  - DONE: busy=0, done=1, pass=(err_count==0).
- Compare: on every readdatavalid (READ or DRAIN), compare readdata to the expected LFSR and advance it. A mismatch increments err_count, saturating at 16'hFFFF.
- readdatavalid while IDLE/DONE is ignored (no count change).
- Avalon rules: never assert read and write in the same cycle. Request signals and address are stable while waitrequest=1.
- ledr:
  - busy: toggles every BLINK_DIV cycles.
  - done&&pass: 1.
  - done&&!pass: toggles every BLINK_DIV/4 cycles.
  - IDLE after reset: 0.
- Counters (word counter 26-bit, pending counter) must not wrap. Address increments modulo 2^ADDR_W only within the parameter-legal range.
- Reset mid-run: outputs return to reset values immediately. Outstanding readdatavalids after reset release are ignored (state=IDLE).

Optional Feature:
- Macro: SDRAM_TESTER_ERR_CAPTURE_EN.
- When defined, add output ports:
  - first_err_addr  out  ADDR_W: word address of the first mismatching read.
  - first_err_data  out  16: its readdata.
- Both are captured on the first mismatch of a run, held until the next start, and reset to 0.
- A read-address FIFO of depth MAX_PENDING tracks the issued address per outstanding read.
- When undefined: no ports, no FIFO; behaviour otherwise identical.

Test Plan:
- Zero-latency slave, NUM_WORDS=16, start pulse -> 16 writes then 16 reads; done=1, pass=1, err_count=0, ledr=1; first writedata=16'hACE1.
- Slave with random waitrequest (50%) and read latency 3..7 -> address/data stable during stalls; pending never exceeds 8; pass=1.
- Slave corrupts bit 0 of read words 3 and 9 -> err_count=2, pass=0. With the macro defined: first_err_addr=BASE_WORD+3.
- Slave returns readdatavalid simultaneous with a new read accept at pending=8 -> no 9th outstanding read; final count exact.
- fpga_reset_n low for 2 cycles mid-READ with reads outstanding -> all outputs 0. Later valids ignored; next start completes with pass=1.
- start pulsed during WRITE -> ignored; run completes once with exactly NUM_WORDS writes.
